vga_scan_timing: RTL and testbench

- Pixel-timing and output stage for the 640x480@60 game display. It replaces the separate clock divider and sync counters.
- Generates the 25 MHz pixel tick from the 50 MHz board clock, raster counters and pixel coordinates. These feed the line, sprite, message and comparator generators.
- Registers the final 24-bit colour from the RGB mux onto the VGA DAC pins.
- Syncs and blank are delayed so they stay aligned with the colour-path pipeline latency.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_delay_line.sv | 29 ++
 rtl/vga_scan_timing.sv | 145 ++++++++++++++
 tb/tb_vga_scan_timing.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing defaults, derived totals and colour type for the VGA scan stage.
package vga_timing_pkg;

  localparam int H_VIS_DEF = 640;
  localparam int H_FP_DEF  = 16;
  localparam int H_SW_DEF  = 96;
  localparam int H_BP_DEF  = 48;
  localparam int V_VIS_DEF = 480;
  localparam int V_FP_DEF  = 10;
  localparam int V_SW_DEF  = 2;
  localparam int V_BP_DEF  = 33;
  localparam int PIPE_DEF  = 1;

  localparam int H_TOT        = H_VIS_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;
  localparam int V_TOT        = V_VIS_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SW_DEF - 1;
  localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SW_DEF - 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // A total of N positions needs counter values 0..N-1 to fit in 10 bits.
  function automatic logic fits_10b(input int total);
    return (total >= 1) && (total <= 1024);
  endfunction

  function automatic logic in_span(input logic [9:0] c, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a configurable reset word, used to delay sync/blank control.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// VGA pixel tick, raster counters and DAC output register; sync/blank delayed to match colour latency.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VIS = H_VIS_DEF,
  parameter int H_FP  = H_FP_DEF,
  parameter int H_SW  = H_SW_DEF,
  parameter int H_BP  = H_BP_DEF,
  parameter int V_VIS = V_VIS_DEF,
  parameter int V_FP  = V_FP_DEF,
  parameter int V_SW  = V_SW_DEF,
  parameter int V_BP  = V_BP_DEF,
  parameter int PIPE  = PIPE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  output logic        pix_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        frame_end,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_H_SYNC,
  output logic        oVGA_V_SYNC,
  output logic        oVGA_BLANK,
  output logic        oVGA_SYNC,
  output logic        oVGA_CLK
);

  localparam int LINE_LEN    = H_VIS + H_FP + H_SW + H_BP;
  localparam int FRAME_LINES = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SW - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SW - 1);

  if (!fits_10b(LINE_LEN) || !fits_10b(FRAME_LINES)) begin : g_bad_timing
    $error("vga_scan_timing: raster totals must fit 10-bit counters");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
    $error("vga_scan_timing: PIPE must be in 0..4");
  end

  logic       tick_q;
  logic       vga_clk_q;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] ctl_p0;
  logic [2:0] ctl_dly;
  rgb_t       rgb_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;

  // vga_clk_q always holds the complement of tick_q, so the DAC clock rises as each tick ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q    <= 1'b0;
      vga_clk_q <= 1'b1;
    end else begin
      tick_q    <= ~tick_q;
      vga_clk_q <= tick_q;
    end
  end

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick_q) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign video_on  = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign frame_end = tick_q && h_wrap && v_wrap;
  assign hs_raw    = !in_span(h_cnt, HS_FIRST, HS_LAST);
  assign vs_raw    = !in_span(v_cnt, VS_FIRST, VS_LAST);
  assign ctl_p0    = {hs_raw, vs_raw, video_on};

  // ---- stage boundary: control delayed PIPE ticks to meet the upstream colour ----
  if (PIPE == 0) begin : g_no_dly
    assign ctl_dly = ctl_p0;
  end else begin : g_dly
    vga_delay_line #(
      .WIDTH  (3),
      .DEPTH  (PIPE),
      .RST_VAL(3'b110)
    ) u_ctl_dly (
      .clk (clk),
      .rst (rst),
      .en  (tick_q),
      .din (ctl_p0),
      .dout(ctl_dly)
    );
  end

  // ---- stage boundary: pin register; colour is forced black outside the visible area ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (tick_q) begin
      hs_q    <= ctl_dly[2];
      vs_q    <= ctl_dly[1];
      blank_q <= ctl_dly[0];
      rgb_q   <= ctl_dly[0] ? rgb_t'(rgb_in) : '0;
    end
  end

  assign pix_tick    = tick_q;
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign oVGA_R      = rgb_q.r;
  assign oVGA_G      = rgb_q.g;
  assign oVGA_B      = rgb_q.b;
  assign oVGA_H_SYNC = hs_q;
  assign oVGA_V_SYNC = vs_q;
  assign oVGA_BLANK  = blank_q;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_CLK    = vga_clk_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench: three scan instances (default PIPE=1, default PIPE=3, small raster PIPE=2) vs a raster model.
module tb_vga_scan_timing;
  import vga_timing_pkg::*;

  localparam int NI = 3;
  localparam int P_HV [NI] = '{H_VIS_DEF, H_VIS_DEF, 110};
  localparam int P_HF [NI] = '{H_FP_DEF,  H_FP_DEF,  4};
  localparam int P_HS [NI] = '{H_SW_DEF,  H_SW_DEF,  8};
  localparam int P_HB [NI] = '{H_BP_DEF,  H_BP_DEF,  4};
  localparam int P_VV [NI] = '{V_VIS_DEF, V_VIS_DEF, 52};
  localparam int P_VF [NI] = '{V_FP_DEF,  V_FP_DEF,  2};
  localparam int P_VS [NI] = '{V_SW_DEF,  V_SW_DEF,  3};
  localparam int P_VB [NI] = '{V_BP_DEF,  V_BP_DEF,  2};
  localparam int P_PP [NI] = '{1, 3, 2};

  typedef struct {
    int tick, x, y, von, fe, rgb, hs, vs, blank, vclk, ox, oy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rgb_in   [NI];
  logic        pix_tick [NI];
  logic [9:0]  px       [NI];
  logic [9:0]  py       [NI];
  logic        video_on [NI];
  logic        frame_end[NI];
  logic [7:0]  vr       [NI];
  logic [7:0]  vg       [NI];
  logic [7:0]  vb       [NI];
  logic        hs       [NI];
  logic        vs       [NI];
  logic        blank    [NI];
  logic        sync     [NI];
  logic        vclk     [NI];

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  int          cur = 0;
  bit [23:0]   rgb_st [NI];

  always #10 clk = ~clk;

  vga_scan_timing #(.PIPE(1)) u_def (
    .clk(clk), .rst(rst), .rgb_in(rgb_in[0]), .pix_tick(pix_tick[0]), .pixel_x(px[0]),
    .pixel_y(py[0]), .video_on(video_on[0]), .frame_end(frame_end[0]), .oVGA_R(vr[0]),
    .oVGA_G(vg[0]), .oVGA_B(vb[0]), .oVGA_H_SYNC(hs[0]), .oVGA_V_SYNC(vs[0]),
    .oVGA_BLANK(blank[0]), .oVGA_SYNC(sync[0]), .oVGA_CLK(vclk[0]));

  vga_scan_timing #(.PIPE(3)) u_p3 (
    .clk(clk), .rst(rst), .rgb_in(rgb_in[1]), .pix_tick(pix_tick[1]), .pixel_x(px[1]),
    .pixel_y(py[1]), .video_on(video_on[1]), .frame_end(frame_end[1]), .oVGA_R(vr[1]),
    .oVGA_G(vg[1]), .oVGA_B(vb[1]), .oVGA_H_SYNC(hs[1]), .oVGA_V_SYNC(vs[1]),
    .oVGA_BLANK(blank[1]), .oVGA_SYNC(sync[1]), .oVGA_CLK(vclk[1]));

  vga_scan_timing #(.H_VIS(110), .H_FP(4), .H_SW(8), .H_BP(4), .V_VIS(52), .V_FP(2),
                    .V_SW(3), .V_BP(2), .PIPE(2)) u_sm (
    .clk(clk), .rst(rst), .rgb_in(rgb_in[2]), .pix_tick(pix_tick[2]), .pixel_x(px[2]),
    .pixel_y(py[2]), .video_on(video_on[2]), .frame_end(frame_end[2]), .oVGA_R(vr[2]),
    .oVGA_G(vg[2]), .oVGA_B(vb[2]), .oVGA_H_SYNC(hs[2]), .oVGA_V_SYNC(vs[2]),
    .oVGA_BLANK(blank[2]), .oVGA_SYNC(sync[2]), .oVGA_CLK(vclk[2]));

  function automatic int ht(int i);
    return P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction

  function automatic int vt(int i);
    return P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
  endfunction

  function automatic int hof(int i, int n);
    return n % ht(i);
  endfunction

  function automatic int vof(int i, int n);
    return (n / ht(i)) % vt(i);
  endfunction

  function automatic bit vis(int i, int n);
    return hof(i, n) < P_HV[i] && vof(i, n) < P_VV[i];
  endfunction

  // Expected pins c clocks after reset release (c=0 is the reset state itself).
  function automatic exp_t model(int i, int c, bit [23:0] rs);
    exp_t e;
    int   n, m, hm, vm;
    n      = c / 2;
    e.tick = c % 2;
    e.x    = hof(i, n);
    e.y    = vof(i, n);
    e.von  = int'(vis(i, n));
    e.fe   = int'(e.tick == 1 && e.x == ht(i) - 1 && e.y == vt(i) - 1);
    e.vclk = 1 - e.tick;
    e.rgb  = int'(rs);
    m      = n - 1 - P_PP[i];
    if (m < 0) begin
      e.hs = 1; e.vs = 1; e.blank = 0; e.ox = -1; e.oy = -1;
    end else begin
      hm      = hof(i, m);
      vm      = vof(i, m);
      e.ox    = hm;
      e.oy    = vm;
      e.hs    = int'(!(hm >= P_HV[i] + P_HF[i] && hm < P_HV[i] + P_HF[i] + P_HS[i]));
      e.vs    = int'(!(vm >= P_VV[i] + P_VF[i] && vm < P_VV[i] + P_VF[i] + P_VS[i]));
      e.blank = int'(vis(i, m));
    end
    return e;
  endfunction

  function automatic void chk(string nm, int i, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, i, $time, act, expv);
    end
  endfunction

  function automatic void cmp(int i, exp_t e);
    chk("pix_tick", i, int'(pix_tick[i]), e.tick);
    chk("pixel_x", i, int'(px[i]), e.x);
    chk("pixel_y", i, int'(py[i]), e.y);
    chk("video_on", i, int'(video_on[i]), e.von);
    chk("frame_end", i, int'(frame_end[i]), e.fe);
    chk("rgb", i, int'({vr[i], vg[i], vb[i]}), e.rgb);
    chk("h_sync", i, int'(hs[i]), e.hs);
    chk("v_sync", i, int'(vs[i]), e.vs);
    chk("blank", i, int'(blank[i]), e.blank);
    chk("dac_clk", i, int'(vclk[i]), e.vclk);
    chk("sync_on_green", i, int'(sync[i]), 0);
  endfunction

  // One clock of stimulus: set reset, drive colour, push the state expected after the next edge.
  task automatic clock_cycle(input bit r);
    bit        was;
    int        k, m;
    bit [23:0] drv;
    @(negedge clk);
    was = rst;
    rst = r;
    if (was && !r) begin
      #1;
      for (int i = 0; i < NI; i++) cmp(i, model(i, 0, 24'h0));
    end
    for (int i = 0; i < NI; i++) begin
      k   = cur / 2;
      m   = k - P_PP[i];
      drv = 24'($urandom());
      if (r && i != 1 && (cur % 2) == 1 && m >= 0)
        drv = {8'(hof(i, m)), 8'(vof(i, m)), 8'hA5};
      rgb_in[i] = drv;
      if (!r) rgb_st[i] = 24'h0;
      else if ((cur % 2) == 1) rgb_st[i] = (m >= 0 && vis(i, m)) ? drv : 24'h0;
    end
    cur = r ? cur + 1 : 0;
    for (int i = 0; i < NI; i++) sbq.push_back(model(i, cur, rgb_st[i]));
  endtask

  int clk_ct = 0, hs0_fall = -1, vs2_fall = -1, fe_last = -1;
  bit hs0_prev = 1'b1, hs1_prev = 1'b1, vs2_prev = 1'b1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      clk_ct++;
      if (sbq.size() >= NI) begin
        for (int i = 0; i < NI; i++) begin
          e = sbq.pop_front();
          cmp(i, e);
          if (i == 2 && e.ox == 100 && e.oy == 50) begin
            chk("pix_100_50_R", i, int'(vr[i]), 'h64);
            chk("pix_100_50_G", i, int'(vg[i]), 'h32);
            chk("pix_100_50_B", i, int'(vb[i]), 'hA5);
          end
          if (i == 0 && e.ox >= 640) begin
            chk("hblank_rgb", i, int'({vr[i], vg[i], vb[i]}), 0);
            chk("hblank_blank", i, int'(blank[i]), 0);
          end
        end
      end
      if (!rst) begin
        hs0_fall = -1; vs2_fall = -1; fe_last = -1;
        hs0_prev = 1'b1; hs1_prev = 1'b1; vs2_prev = 1'b1;
      end else begin
        if (hs0_prev && !hs[0]) begin
          if (hs0_fall >= 0) chk("hs_period_clks", 0, clk_ct - hs0_fall, 1600);
          hs0_fall = clk_ct;
        end
        if (!hs0_prev && hs[0] && hs0_fall >= 0) chk("hs_low_clks", 0, clk_ct - hs0_fall, 192);
        if (hs1_prev && !hs[1] && hs0_fall >= 0) chk("pipe3_hs_shift", 1, clk_ct - hs0_fall, 4);
        if (vs2_prev && !vs[2]) vs2_fall = clk_ct;
        if (!vs2_prev && vs[2] && vs2_fall >= 0)
          chk("vs_low_clks", 2, clk_ct - vs2_fall, 2 * P_VS[2] * ht(2));
        if (frame_end[2]) begin
          if (fe_last >= 0) chk("frame_period", 2, clk_ct - fe_last, 2 * ht(2) * vt(2));
          fe_last = clk_ct;
        end
        hs0_prev = hs[0];
        hs1_prev = hs[1];
        vs2_prev = vs[2];
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < NI; i++) begin
      rgb_in[i] = 24'h0;
      rgb_st[i] = 24'h0;
    end
    repeat (4) clock_cycle(1'b0);
    // reset mid-frame with the default raster at h=700, v=3
    while (cur != 2 * (3 * 800 + 700) + 1) clock_cycle(1'b1);
    repeat (3) clock_cycle(1'b0);
    repeat (2 * 2 * ht(2) * vt(2) + 400) clock_cycle(1'b1);
    repeat ($urandom_range(50, 3000)) clock_cycle(1'b1);
    repeat ($urandom_range(1, 4)) clock_cycle(1'b0);
    repeat (4000) clock_cycle(1'b1);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 0, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
